// File: rtl/lsu_pkg.sv
// Shared types and lane-mask constants for the sub-word load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_RSV = 2'b11
   } size_e;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_e;

   localparam logic [3:0] LANE_MASK_B = 4'b0001;
   localparam logic [3:0] LANE_MASK_H = 4'b0011;
   localparam logic [3:0] LANE_MASK_W = 4'b1111;

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: load extract/extend and store merge into a word.
module lsu_lane_unit
   import lsu_pkg::*;
(
   input  size_e       ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data,
   input  size_e       st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_base,
   input  logic [31:0] st_data,
   output logic [31:0] st_word
);

   logic [31:0] shifted;
   logic [31:0] st_rep;
   logic [3:0]  st_be;

   always_comb begin
      shifted = ld_word >> {ld_off, 3'b000};
      case (ld_size)
         SZ_B:    ld_data = ld_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    ld_data = ld_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
         default: ld_data = ld_word;
      endcase
   end

   // Replicate the store data across all lanes, then pick lanes by byte enable.
   always_comb begin
      st_rep  = st_data;
      st_be   = LANE_MASK_W;
      st_word = st_base;
      case (st_size)
         SZ_B: begin
            st_rep = {4{st_data[7:0]}};
            st_be  = LANE_MASK_B << st_off;
         end
         SZ_H: begin
            st_rep = {2{st_data[15:0]}};
            st_be  = LANE_MASK_H << st_off;
         end
         default: ;
      endcase
      for (int i = 0; i < 4; i++) begin
         if (st_be[i]) st_word[8*i +: 8] = st_rep[8*i +: 8];
      end
   end

endmodule

// File: rtl/lsu_subword_rmw.sv
// Word-only RAM front end: sub-word loads, 2-cycle read-modify-write sub-word stores.
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses return an error instead of aligning.
//
// state  | meaning
// IDLE   | accepting requests; loads and word stores complete in one cycle
// RMW_WR | writing merged word for a captured sub-word store; requests ignored
module lsu_subword_rmw
   import lsu_pkg::*;
#(
   parameter int          AW          = 32,
   parameter logic [31:0] RESET_RDATA = 32'h0000_0000
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [31:0]   mem_wd,
   input  logic [31:0]   mem_rd
);

   state_e        state;
   logic [AW-1:0] addr_q;
   size_e         size_q;
   logic [31:0]   wdata_q;
   logic [31:0]   merge_q;

   size_e         req_sz;
   logic [1:0]    req_off;
   logic          req_err;
   logic [31:0]   ld_data;
   logic [31:0]   st_word;

   // req_off is the lane offset after silently dropping misaligned low bits.
   always_comb begin
      req_sz = size_e'(req_size);
      case (req_sz)
         SZ_B:    req_off = req_addr[1:0];
         SZ_H:    req_off = {req_addr[1], 1'b0};
         default: req_off = 2'b00;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      req_err = (req_sz == SZ_RSV)
             || (req_sz == SZ_H && req_addr[0])
             || (req_sz == SZ_W && req_addr[1:0] != 2'b00);
`else
      req_err = (req_sz == SZ_RSV);
`endif
   end

   lsu_lane_unit u_lane (
      .ld_size     (req_sz),
      .ld_off      (req_off),
      .ld_unsigned (req_unsigned),
      .ld_word     (mem_rd),
      .ld_data     (ld_data),
      .st_size     (size_q),
      .st_off      (addr_q[1:0]),
      .st_base     (merge_q),
      .st_data     (wdata_q),
      .st_word     (st_word)
   );

   always_comb begin
      req_ready = (state == IDLE);
      if (state == RMW_WR) begin
         mem_a  = {addr_q[AW-1:2], 2'b00};
         mem_wd = st_word;
         mem_we = 1'b1;
      end else begin
         mem_a  = {req_addr[AW-1:2], 2'b00};
         mem_wd = req_wdata;
         mem_we = req_valid && req_we && (req_sz == SZ_W) && !req_err;
      end
      if (!rst_n) mem_we = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         size_q    <= SZ_B;
         wdata_q   <= 32'h0;
         merge_q   <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= RESET_RDATA;
      end else begin
         case (state)
            IDLE: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               if (req_valid) begin
                  if (req_err) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= RESET_RDATA;
                  end else if (!req_we) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= ld_data;
                  end else if (req_sz == SZ_W) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= RESET_RDATA;
                  end else begin
                     state   <= RMW_WR;
                     addr_q  <= {req_addr[AW-1:2], req_off};
                     size_q  <= req_sz;
                     wdata_q <= req_wdata;
                     merge_q <= mem_rd;
                  end
               end
            end
            RMW_WR: begin
               state     <= IDLE;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= RESET_RDATA;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
